// File: rtl/grad_gen.sv
// grad_gen: streaming 3x3 Sobel gradient generator.
// Takes raster-order grey pixels and produces registered |Gx| (in1) and
// |Gy| (in2) for every complete 3x3 window, two clock edges after the
// pixel that completes the window is accepted.
// Optional build macro GRAD_SHIFT_EN: when defined, magnitudes are divided
// by 4 (right shift by 2) instead of being saturated to 2^PIX_W-1.
//
// Handshake: pix_in/sof are consumed on every rising edge with pix_valid=1
// (no ready, the block never stalls); out_valid is a one-cycle pulse
// marking a fresh in1/in2 pair, and the consumer is assumed always ready.
module grad_gen #(
   parameter int LINE_W = 64,
   parameter int PIX_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   input  logic             sof,
   output logic [PIX_W-1:0] in1,
   output logic [PIX_W-1:0] in2,
   output logic             out_valid
);

   localparam int CW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
   localparam int SW = PIX_W + 3;

   logic [CW-1:0]    col;
   logic [1:0]       row;
   logic [CW-1:0]    eff_col;
   logic [1:0]       eff_row;
   logic             last_col;
   logic             complete;
   logic             win_valid;

   logic [PIX_W-1:0] lb0 [LINE_W];   // row two above the current one
   logic [PIX_W-1:0] lb1 [LINE_W];   // row directly above the current one
   logic [PIX_W-1:0] w   [3][3];     // w[r][c]: r=0 oldest row, c=0 oldest column

   logic signed [SW-1:0] gx;
   logic signed [SW-1:0] gy;

   // A start-of-frame pixel is treated as row 0, column 0 whatever the counters say.
   assign eff_col  = sof ? '0 : col;
   assign eff_row  = sof ? '0 : row;
   assign last_col = (eff_col == CW'(LINE_W - 1));
   assign complete = pix_valid && (eff_row == 2'd2) && (eff_col >= CW'(2));

   function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
      return $signed({3'b000, p});
   endfunction

   // Absolute value reduced to PIX_W bits (shift or saturate by build option).
   function automatic logic [PIX_W-1:0] mag_f(input logic signed [SW-1:0] g);
      logic [SW-1:0] a;
      a = g[SW-1] ? SW'(-g) : SW'(g);
`ifdef GRAD_SHIFT_EN
      return PIX_W'(a >> 2);
`else
      return (a > SW'({PIX_W{1'b1}})) ? {PIX_W{1'b1}} : PIX_W'(a);
`endif
   endfunction

   // Sobel kernels on the window: right column minus left, bottom row minus top.
   assign gx = (ext(w[0][2]) + (ext(w[1][2]) <<< 1) + ext(w[2][2]))
             - (ext(w[0][0]) + (ext(w[1][0]) <<< 1) + ext(w[2][0]));
   assign gy = (ext(w[2][0]) + (ext(w[2][1]) <<< 1) + ext(w[2][2]))
             - (ext(w[0][0]) + (ext(w[0][1]) <<< 1) + ext(w[0][2]));

   // Column/row position of the next pixel; row saturates at 2 (enough to gate windows).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col <= '0;
         row <= '0;
      end else if (pix_valid) begin
         if (last_col) begin
            col <= '0;
            row <= (eff_row == 2'd2) ? 2'd2 : 2'(eff_row + 2'd1);
         end else begin
            col <= CW'(eff_col + CW'(1));
            row <= eff_row;
         end
      end
   end

   // Line buffers shift one row down per column; no reset, row gating hides stale data.
   always_ff @(posedge clk) begin
      if (pix_valid) begin
         lb0[eff_col] <= lb1[eff_col];
         lb1[eff_col] <= pix_in;
      end
   end

   // Window shifts left one column per accepted pixel; new column is lb0, lb1, pix_in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               w[r][c] <= '0;
            end
         end
      end else if (pix_valid) begin
         for (int r = 0; r < 3; r++) begin
            w[r][0] <= w[r][1];
            w[r][1] <= w[r][2];
         end
         w[0][2] <= lb0[eff_col];
         w[1][2] <= lb1[eff_col];
         w[2][2] <= pix_in;
      end
   end

   // Marks that the window just loaded is a complete one (one cycle pulse).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_valid <= 1'b0;
      end else begin
         win_valid <= complete;
      end
   end

   // Output register: new magnitudes only when a complete window is present, else hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in1       <= '0;
         in2       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= win_valid;
         if (win_valid) begin
            in1 <= mag_f(gx);
            in2 <= mag_f(gy);
         end
      end
   end

endmodule

// File: tb/tb_grad_gen.sv
// Bench for grad_gen (LINE_W=8): directed frames, reference image model,
// expected-result queue and a negedge monitor that checks values, latency,
// hold behaviour and reset state.
module tb_grad_gen;

   localparam int LINE_W = 8;
   localparam int PIX_W  = 8;
   localparam int MAXR   = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [PIX_W-1:0] pix_in;
   logic             pix_valid;
   logic             sof;
   logic [PIX_W-1:0] in1;
   logic [PIX_W-1:0] in2;
   logic             out_valid;

   logic [2*PIX_W-1:0] exp_q[$];
   int                 edge_q[$];

   int checks = 0;
   int errors = 0;
   int nout   = 0;
   int cyc    = 0;
   int mr     = 0;
   int mc     = 0;
   int img [MAXR][LINE_W];
   logic [2*PIX_W-1:0] last_g = '0;

   grad_gen #(.LINE_W(LINE_W), .PIX_W(PIX_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .pix_in   (pix_in),
      .pix_valid(pix_valid),
      .sof      (sof),
      .in1      (in1),
      .in2      (in2),
      .out_valid(out_valid)
   );

   // clock / edge counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int reduce(input int g);
      int a;
      a = (g < 0) ? -g : g;
`ifdef GRAD_SHIFT_EN
      return a / 4;
`else
      return (a > 255) ? 255 : a;
`endif
   endfunction

   function automatic int pix_val(input int mode, input int r, input int c);
      case (mode)
         0: return 100;
         1: return (c < 4) ? 0 : 100;
         2: return (r < 3) ? 0 : 50;
         default: return (r * 37 + c * 11 + 5) % 256;
      endcase
   endfunction

   // driver: one input cycle; reference model tracks frame position and image
   task automatic drive(input int p, input bit s, input bit v);
      int gx, gy;
      pix_in    = PIX_W'(p);
      sof       = s;
      pix_valid = v;
      if (v) begin
         if (s) begin
            mr = 0;
            mc = 0;
         end
         img[mr][mc] = p;
         if (mr >= 2 && mc >= 2) begin
            gx = (img[mr-2][mc] + 2 * img[mr-1][mc] + img[mr][mc])
               - (img[mr-2][mc-2] + 2 * img[mr-1][mc-2] + img[mr][mc-2]);
            gy = (img[mr][mc-2] + 2 * img[mr][mc-1] + img[mr][mc])
               - (img[mr-2][mc-2] + 2 * img[mr-2][mc-1] + img[mr-2][mc]);
            exp_q.push_back({PIX_W'(reduce(gx)), PIX_W'(reduce(gy))});
            edge_q.push_back(cyc + 1);
         end
         mc++;
         if (mc == LINE_W) begin
            mc = 0;
            if (mr < MAXR - 1) mr++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 1'b0, 1'b0);
   endtask

   // nrows full rows then ncols pixels of the next row; optional gap after each pixel
   task automatic send_part(input int mode, input int nrows, input int ncols,
                            input bit use_sof, input bit gaps);
      int total;
      total = nrows * LINE_W + ncols;
      for (int k = 0; k < total; k++) begin
         drive(pix_val(mode, k / LINE_W, k % LINE_W), use_sof && (k == 0), 1'b1);
         if (gaps) idle(1);
      end
   endtask

   task automatic drain_and_count(input string name, input int base, input int exp_n);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         idle(1);
         n++;
      end
      if (exp_q.size() != 0) begin
         chk({name, "_drain_timeout"}, exp_q.size(), 0);
         exp_q.delete();
         edge_q.delete();
      end
      idle(3);
      chk({name, "_count"}, nout - base, exp_n);
   endtask

   task automatic reset_pulse();
      rst = 1'b0;
      mr  = 0;
      mc  = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [2*PIX_W-1:0] e;
      int ed;
      if (rst === 1'b0) begin
         chk("reset_in1", int'(in1), 0);
         chk("reset_in2", int'(in2), 0);
         chk("reset_valid", int'(out_valid), 0);
         last_g = '0;
      end else if (out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("spurious_valid", 1, 0);
         end else begin
            e  = exp_q.pop_front();
            ed = edge_q.pop_front();
            chk("in1_gx", int'(in1), int'(e[2*PIX_W-1:PIX_W]));
            chk("in2_gy", int'(in2), int'(e[PIX_W-1:0]));
            chk("latency", cyc, ed + 1);
            last_g = e;
            nout++;
         end
      end else begin
         chk("hold_in1", int'(in1), int'(last_g[2*PIX_W-1:PIX_W]));
         chk("hold_in2", int'(in2), int'(last_g[PIX_W-1:0]));
      end
   end

   initial begin
      int base;
      rst       = 1'b0;
      pix_in    = '0;
      pix_valid = 1'b0;
      sof       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      idle(2);

      // flat frame: 6 windows per line from row 2, all zero gradients
      base = nout;
      send_part(0, 4, 0, 1'b1, 1'b0);
      drain_and_count("flat", base, 12);

      // vertical edge at column 4
      base = nout;
      send_part(1, 4, 0, 1'b1, 1'b0);
      drain_and_count("vedge", base, 12);

      // horizontal edge at row 3
      base = nout;
      send_part(2, 6, 0, 1'b1, 1'b0);
      drain_and_count("hedge", base, 24);

      // flat frame with pix_valid toggling every cycle
      base = nout;
      send_part(0, 4, 0, 1'b1, 1'b1);
      drain_and_count("gaps", base, 12);

      // textured frame with gaps
      base = nout;
      send_part(3, 5, 0, 1'b1, 1'b1);
      drain_and_count("texture", base, 18);

      // sof at column 5 of row 3 restarts the frame
      base = nout;
      send_part(3, 3, 5, 1'b1, 1'b0);
      send_part(3, 4, 0, 1'b1, 1'b0);
      drain_and_count("midsof", base, 21);

      // reset in the middle of row 4, new data without sof
      base = nout;
      send_part(3, 4, 4, 1'b1, 1'b0);
      idle(3);
      reset_pulse();
      send_part(1, 3, 0, 1'b0, 1'b0);
      drain_and_count("midrst", base, 20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/grad_gen.md
GRAD_GEN -- requirements
Module: grad_gen

Interface
REQ-001 The block SHALL have parameter LINE_W, default 64, meaning pixels per image line (3..1024).
REQ-002 The block SHALL have parameter PIX_W, default 8, meaning pixel and output magnitude width in bits.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port pix_in, input, PIX_W bits: unsigned grey pixel, raster order.
REQ-006 Port pix_valid, input, 1 bit: pix_in is accepted on a rising edge where pix_valid=1.
REQ-007 Port sof, input, 1 bit: start of frame; meaningful only with pix_valid=1; marks that pixel as row 0, column 0.
REQ-008 Port in1, output, PIX_W bits: horizontal gradient magnitude |Gx|, registered, feeds the sqrt block's in1.
REQ-009 Port in2, output, PIX_W bits: vertical gradient magnitude |Gy|, registered, feeds the sqrt block's in2.
REQ-010 Port out_valid, output, 1 bit: in1/in2 hold a new window result for exactly this cycle.

Function
REQ-011 The block SHALL keep two line buffers of LINE_W x PIX_W holding the previous two rows, plus a 3x3 window register.
REQ-012 Column counter SHALL run 0..LINE_W-1 and wrap to 0 on the next accepted pixel; row counter SHALL increment on wrap and saturate at 2.
REQ-013 An accepted pixel with sof=1 SHALL force column=0 and row=0 for that pixel, regardless of current counts (mid-line sof restarts the frame).
REQ-014 Cycles with pix_valid=0 SHALL leave counters, line buffers and window unchanged; gaps of any length are legal.
REQ-015 Window w[r][c] (r=0 oldest row, c=0 oldest column) SHALL shift by one column per accepted pixel.
REQ-016 Gx SHALL equal (w02+2*w12+w22)-(w00+2*w10+w20); Gy SHALL equal (w20+2*w21+w22)-(w00+2*w01+w02); intermediates signed, PIX_W+3 bits.
REQ-017 Magnitude SHALL be absolute value of Gx/Gy, then reduced to PIX_W bits per REQ-025/026.
REQ-018 A window is complete when the accepted pixel has row>=2 and column>=2; the first two columns of each line SHALL produce no result.
REQ-019 Latency: for a completing pixel accepted on edge N, out_valid=1 and in1/in2 valid in the cycle after edge N+1 (two edges).
REQ-020 out_valid SHALL be a single-cycle pulse per completed window; back-to-back pixels give back-to-back pulses.
REQ-021 in1/in2 SHALL hold their last value while out_valid=0.
REQ-022 No backpressure: every result SHALL be produced; the consumer is always ready.

Reset
REQ-023 While rst=0: in1=0, in2=0, out_valid=0, column=0, row=0, window=0, pipeline valid flags=0, asynchronously.
REQ-024 Line-buffer contents SHALL NOT need clearing; row<2 gating guarantees no stale data reaches out_valid, including reset mid-frame.

Configuration
REQ-025 Without GRAD_SHIFT_EN defined: magnitude SHALL saturate to 2^PIX_W-1 (255 for PIX_W=8).
REQ-026 With GRAD_SHIFT_EN defined: magnitude SHALL be right-shifted by 2 (|G|max 4*(2^PIX_W-1) fits exactly), no saturation logic.

Verification
REQ-027 Flat frame, all pixels 100, LINE_W=8 -> out_valid pulses 6 per line from row 2, in1=0, in2=0.
REQ-028 Vertical edge: columns 0-3 =0, 4-7 =100 -> at window spanning 3..5: in1=255 (400 saturated), in2=0; with GRAD_SHIFT_EN in1=100.
REQ-029 Horizontal edge: rows 0-2 =0, rows 3+ =50 -> first row-3 windows in2=200, in1=0; with GRAD_SHIFT_EN in2=50.
REQ-030 pix_valid toggled 1-0-1 every cycle on flat frame -> same result count as REQ-027, each out_valid two edges after completing pixel.
REQ-031 sof asserted at column 5 of row 3 -> no out_valid until new row 2, column 2 reached.
REQ-032 rst driven low mid-row 4 for one cycle -> outputs 0 immediately, no out_valid until row 2, column 2 of new data.
